// File: rtl/wbuf_pkg.sv
// Shared definitions for the CMU write buffer: FSM encoding, default depth
// and the buffered-entry layout.
package wbuf_pkg;
    localparam int WBUF_DEPTH = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wbuf_entry_t;
endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write storage: circular entry array with head/tail/count and a
// youngest-match word-address lookup across every occupied entry.
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wbuf_entry_t   push_ent,
    input  logic          pop,
    output wbuf_entry_t   head_ent,
    output logic [AW:0]   count,
    input  logic [29:0]   lk_word,
    output logic          lk_hit,
    output logic [31:0]   lk_data
);
    wbuf_entry_t   mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW-1:0] idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_ent;
    end

    assign head_ent = mem[head];

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + AW'(k);
            if (((AW+1)'(k) < count) && (mem[idx].addr[31:2] == lk_word)) begin
                lk_hit  = 1'b1;
                lk_data = mem[idx].data;
            end
        end
    end
endmodule

// File: rtl/cmu_wbuf.sv
// Write buffer between the CMU port and data_ram: posts writes, forwards
// read hits from the buffer, and serialises drains and read misses.
module cmu_wbuf
    import wbuf_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_cs,
    input  logic                     up_we,
    input  logic [31:0]              up_addr,
    input  logic [31:0]              up_wdata,
    output logic [31:0]              up_rdata,
    output logic                     up_ack,
    output logic                     mem_cs_o,
    output logic                     mem_we_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_data_o,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_ack_i,
    output logic [$clog2(DEPTH):0]   wbuf_count,
    output logic [2:0]               wbuf_state
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]   state;
    wbuf_entry_t  head_ent;
    logic [AW:0]  count;
    logic         lk_hit;
    logic [31:0]  lk_data;
    logic         accept, wr_acc, rd_hit, rd_miss, pop;

    // While READ is outstanding the held request is the miss being served.
    assign accept  = up_cs && !up_ack && (state != ST_READ);
    assign wr_acc  = accept && up_we && (count < (AW+1)'(DEPTH));
    assign rd_hit  = accept && !up_we && lk_hit;
    assign rd_miss = accept && !up_we && !lk_hit;
    assign pop     = (state == ST_DRAIN) && mem_ack_i;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_acc),
        .push_ent ('{addr: up_addr, data: up_wdata}),
        .pop      (pop),
        .head_ent (head_ent),
        .count    (count),
        .lk_word  (up_addr[31:2]),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data)
    );

    assign wbuf_count = count;
    assign wbuf_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            up_ack     <= 1'b0;
            up_rdata   <= '0;
            mem_cs_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            up_ack <= wr_acc || rd_hit;
            if (rd_hit) up_rdata <= lk_data;
            case (state)
                // A pending miss wins over starting a new drain.
                ST_IDLE: begin
                    if (rd_miss) begin
                        state      <= ST_READ;
                        mem_cs_o   <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= up_addr;
                        mem_data_o <= '0;
                    end else if (count != '0) begin
                        state      <= ST_DRAIN;
                        mem_cs_o   <= 1'b1;
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= head_ent.addr;
                        mem_data_o <= head_ent.data;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack_i) begin
                        state    <= ST_IDLE;
                        mem_cs_o <= 1'b0;
                        mem_we_o <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (mem_ack_i) begin
                        state    <= ST_RESP;
                        mem_cs_o <= 1'b0;
                        up_rdata <= mem_data_i;
                        up_ack   <= 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/cmu_wbuf.md
CMU_WBUF -- requirements
Module: cmu_wbuf

Interface
REQ-001 Parameter DEPTH, default 4, number of write-buffer entries; SHALL be a power of two, minimum 2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 up_cs, up_we  in  1 each  CMU-side request and write-select; level-held until up_ack.
REQ-005 up_addr, up_wdata  in  32 each  CMU-side word address and write data.
REQ-006 up_rdata  out  32  registered read data to the CMU.
REQ-007 up_ack  out  1  registered one-cycle completion pulse to the CMU.
REQ-008 mem_cs_o, mem_we_o  out  1 each  data_ram request and write-select.
REQ-009 mem_addr_o, mem_data_o  out  32 each  data_ram address and write data.
REQ-010 mem_data_i  in  32  data_ram read data; mem_ack_i  in  1  data_ram completion pulse.
REQ-011 wbuf_count  out  $clog2(DEPTH)+1  entries occupied; wbuf_state  out  3  FSM state for CPUTEST.

Function
REQ-012 The block sits between the CMU memory port and data_ram and posts CMU writes into a FIFO.
REQ-013 A request is accepted only when up_cs=1 and up_ack=0 in the current cycle.
REQ-014 Consequence of REQ-013: the block accepts at most one request per 2 cycles.
REQ-015 Write accept requires up_we=1 and count<DEPTH; the entry is enqueued at the edge; up_ack=1 the next cycle.
REQ-016 Write with FIFO full: no ack; the request stalls until a drain pop frees an entry.
REQ-017 Read hit: up_addr[31:2] matches a FIFO entry, including the entry currently draining.
REQ-018 Read hit: up_rdata is the youngest matching entry's data; up_ack=1 the next cycle; no RAM access.
REQ-019 Read miss: the block waits for any outstanding drain to receive mem_ack_i, then issues the RAM read.
REQ-020 Read miss: on mem_ack_i it latches mem_data_i into up_rdata; up_ack=1 the next cycle.
REQ-021 FSM states: IDLE=0, DRAIN=1, READ=2, RESP=3.
REQ-022 IDLE->READ on a read miss; IDLE->DRAIN when count>0 and no read miss is pending.
REQ-023 DRAIN->IDLE on mem_ack_i; the head entry is popped at that edge.
REQ-024 READ->RESP on mem_ack_i; RESP->IDLE after one cycle.
REQ-025 Read misses take priority over starting a new drain; an in-flight drain is never aborted.
REQ-026 mem_cs_o, mem_we_o, mem_addr_o and mem_data_o SHALL hold stable from issue until the cycle mem_ack_i=1.
REQ-027 mem_cs_o SHALL be 0 in the cycle after mem_ack_i; back-to-back RAM requests have one idle cycle between them.
REQ-028 Enqueue and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
REQ-029 A write to an address already buffered creates a new entry; entries are not merged.
REQ-030 Downstream write order equals CMU write order.
REQ-031 mem_ack_i in IDLE or RESP SHALL be ignored.

Reset
REQ-032 While rst=0: state=IDLE, count=0, pointers=0, and all outputs are 0.
REQ-033 Reset mid-operation discards all buffered writes and any outstanding RAM transaction without completing it.

Structure
REQ-034 Package wbuf_pkg holds the FSM state encoding and the DEPTH default.
REQ-035 One sub-module, wbuf_fifo, holds entry storage, head/tail pointers, count, and the youngest-match search.
REQ-036 The FSM and handshake logic reside in cmu_wbuf.

Verification
REQ-037 Three writes (0x100/0x11, 0x104/0x22, 0x108/0x33) with 2-cycle mem_ack_i latency: three acks; RAM writes occur in the same order; count returns to 0.
REQ-038 With RAM ack withheld, write A0..A4 at DEPTH=4: four acks, then the fifth stalls until the first mem_ack_i; its ack follows one cycle after the pop.
REQ-039 Write 0x200=0xAA, then 0x200=0xBB, then read 0x200 before either drains: up_rdata=0xBB, up_ack next cycle, no mem_cs_o with we=0.
REQ-040 Read miss 0x300 while a drain is in flight: the read issues only after the drain ack; up_rdata equals mem_data_i 0xDEAD; up_ack one cycle after mem_ack_i.
REQ-041 Assert rst=0 with 3 entries buffered during DRAIN: all outputs are 0 immediately; after release no RAM writes occur and count=0.
